// File: rtl/video_pkg.sv
// Shared video definitions: default resolution, coordinate width, pattern and
// sequencer state encodings used across the pixel-clock datapath.
package video_pkg;

  localparam int H_RES_DEF = 1024;
  localparam int V_RES_DEF = 768;
  localparam int COORD_W   = 13;

  typedef enum logic [1:0] {
    PAT_GRADIENT = 2'd0,
    PAT_BARS     = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_BOX      = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    RUN       = 2'd1,
    PAUSED    = 2'd2
  } seq_state_e;

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: position and direction registers that step by
// STEP per enabled frame, clamping at 0 and LIM and reversing there.
module bounce_axis
  import video_pkg::*;
#(
  parameter int LIM  = 960,
  parameter int STEP = 4
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  input  logic               step_en,
  output logic [COORD_W-1:0] pos
);

  localparam logic [COORD_W-1:0] LIM_C  = COORD_W'(LIM);
  localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);

  logic [COORD_W-1:0] pos_r;
  logic [COORD_W-1:0] pos_nxt_s;
  logic               dir_r;
  logic               dir_nxt_s;
  logic [COORD_W:0]   sum_s;

  // Next position: one extra bit on the sum so the upper clamp never wraps.
  always_comb begin
    sum_s     = {1'b0, pos_r} + {1'b0, STEP_C};
    pos_nxt_s = pos_r;
    dir_nxt_s = dir_r;
    if (step_en) begin
      if (dir_r) begin
        if (sum_s >= {1'b0, LIM_C}) begin
          pos_nxt_s = LIM_C;
          dir_nxt_s = 1'b0;
        end else begin
          pos_nxt_s = sum_s[COORD_W-1:0];
        end
      end else begin
        if (pos_r <= STEP_C) begin
          pos_nxt_s = {COORD_W{1'b0}};
          dir_nxt_s = 1'b1;
        end else begin
          pos_nxt_s = pos_r - STEP_C;
        end
      end
    end else begin
      pos_nxt_s = pos_r;
    end
  end

  // Position/direction registers; direction 1 means moving towards LIM.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      pos_r <= {COORD_W{1'b0}};
      dir_r <= 1'b1;
    end else begin
      pos_r <= pos_nxt_s;
      dir_r <= dir_nxt_s;
    end
  end

  assign pos = pos_r;

endmodule

// File: rtl/frame_sequencer_checker.sv
// Property checks for frame_sequencer: the update point must fall in blanking.
module frame_sequencer_checker (
  input logic clk_pix,
  input logic rst_pix,
  input logic upd,
  input logic active
);

  upd_in_blanking_a: assert property (@(posedge clk_pix) disable iff (rst_pix) !(upd && active))
    else $error("update point coincides with active video");

endmodule

// File: rtl/frame_sequencer.sv
// Once-per-frame controller: on the first blanking line it advances the
// pattern selection and moves the bouncing box, so outputs are stable in active video.
module frame_sequencer
  import video_pkg::*;
#(
  parameter int H_RES          = H_RES_DEF,
  parameter int V_RES          = V_RES_DEF,
  parameter int BOX_SIZE       = 64,
  parameter int BOX_STEP       = 4,
  parameter int FRAMES_PER_PAT = 120,
  parameter int NUM_PATS       = 4
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  input  logic [COORD_W-1:0] h,
  input  logic [COORD_W-1:0] v,
  input  logic               active,
  input  logic               next_req,
  input  logic               hold,
  output logic [1:0]         pat_sel,
  output logic [COORD_W-1:0] box_x,
  output logic [COORD_W-1:0] box_y,
  output logic               frame_tick,
  output logic [15:0]        frame_cnt
);

  localparam logic [COORD_W-1:0] V_RES_C    = COORD_W'(V_RES);
  localparam logic [15:0]        CNT_LAST_C = 16'(FRAMES_PER_PAT - 1);
  localparam logic [1:0]         PAT_LAST_C = 2'(NUM_PATS - 1);

  seq_state_e  state_r;
  seq_state_e  state_nxt_s;
  logic        pend_r;
  logic        pend_nxt_s;
  logic [1:0]  pat_r;
  logic [1:0]  pat_nxt_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic        tick_r;
  logic        upd_s;
  logic        req_s;
  logic        move_s;
  logic        adv_s;

  assign upd_s = (h == {COORD_W{1'b0}}) && (v == V_RES_C);
  // A request arriving on the update cycle itself is honoured immediately.
  assign req_s = pend_r | next_req;

  // Next-state and advance decision, evaluated only at the update point.
  always_comb begin
    state_nxt_s = state_r;
    pend_nxt_s  = req_s;
    pat_nxt_s   = pat_r;
    cnt_nxt_s   = cnt_r;
    move_s      = 1'b0;
    adv_s       = 1'b0;
    if (upd_s) begin
      case (state_r)
        SYNC_WAIT: state_nxt_s = RUN;
        RUN, PAUSED: begin
          pend_nxt_s = 1'b0;
          if (hold) begin
            state_nxt_s = PAUSED;
            adv_s       = req_s;
          end else begin
            state_nxt_s = RUN;
            move_s      = 1'b1;
            if (req_s || (cnt_r == CNT_LAST_C)) begin
              adv_s = 1'b1;
            end else begin
              cnt_nxt_s = cnt_r + 16'd1;
            end
          end
        end
        default: state_nxt_s = SYNC_WAIT;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
    if (adv_s) begin
      pat_nxt_s = (pat_r == PAT_LAST_C) ? 2'd0 : pat_r + 2'd1;
      cnt_nxt_s = 16'd0;
    end else begin
      pat_nxt_s = pat_r;
    end
  end

  // Sequencer registers; frame_tick marks the cycle after each update point.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_r <= SYNC_WAIT;
      pend_r  <= 1'b0;
      pat_r   <= PAT_GRADIENT;
      cnt_r   <= 16'd0;
      tick_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pend_r  <= pend_nxt_s;
      pat_r   <= pat_nxt_s;
      cnt_r   <= cnt_nxt_s;
      tick_r  <= upd_s;
    end
  end

  bounce_axis #(.LIM(H_RES - BOX_SIZE), .STEP(BOX_STEP)) u_axis_x (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .step_en (move_s),
    .pos     (box_x)
  );

  bounce_axis #(.LIM(V_RES - BOX_SIZE), .STEP(BOX_STEP)) u_axis_y (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .step_en (move_s),
    .pos     (box_y)
  );

  frame_sequencer_checker u_chk (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .upd     (upd_s),
    .active  (active)
  );

  assign pat_sel    = pat_r;
  assign frame_cnt  = cnt_r;
  assign frame_tick = tick_r;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer on a tiny 16x8 raster (20x10 total)
// with hand-computed expected outputs after each update point.
module tb_frame_sequencer;

  localparam int H_RES = 16;
  localparam int V_RES = 8;
  localparam logic [12:0] H_LAST_C = 13'd19;
  localparam logic [12:0] V_LAST_C = 13'd9;
  localparam logic [12:0] V_UPD_C  = 13'd8;

  logic        clk_pix = 1'b0;
  logic        rst_pix;
  logic [12:0] h;
  logic [12:0] v;
  logic        active;
  logic        next_req;
  logic        hold;
  logic [1:0]  pat_sel;
  logic [12:0] box_x;
  logic [12:0] box_y;
  logic        frame_tick;
  logic [15:0] frame_cnt;

  int errors     = 0;
  int checks     = 0;
  int ticks_seen = 0;

  always #5 clk_pix = ~clk_pix;

  frame_sequencer #(
    .H_RES(H_RES), .V_RES(V_RES), .BOX_SIZE(4), .BOX_STEP(3),
    .FRAMES_PER_PAT(2), .NUM_PATS(4)
  ) dut (
    .clk_pix    (clk_pix),
    .rst_pix    (rst_pix),
    .h          (h),
    .v          (v),
    .active     (active),
    .next_req   (next_req),
    .hold       (hold),
    .pat_sel    (pat_sel),
    .box_x      (box_x),
    .box_y      (box_y),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample just after the edge, then advance the raster counters.
  task automatic cyc();
    @(posedge clk_pix);
    #1;
    if (frame_tick === 1'b1) ticks_seen++;
    if (h == H_LAST_C) begin
      h = 13'd0;
      v = (v == V_LAST_C) ? 13'd0 : v + 13'd1;
    end else begin
      h = h + 13'd1;
    end
    active = (h < 13'd16) && (v < 13'd8);
  endtask

  task automatic to_upd();
    int n = 0;
    while (!(h == 13'd0 && v == V_UPD_C) && n < 1000) begin
      cyc();
      n++;
    end
    if (n >= 1000) check_eq("upd_timeout", n, 0);
  endtask

  task automatic frame();
    to_upd();
    cyc();
  endtask

  task automatic mid(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse_req();
    next_req = 1'b1;
    cyc();
    next_req = 1'b0;
  endtask

  task automatic exp_out(input string tag, input int pat, input int cnt, input int x, input int y, input int tick);
    check_eq({tag, "_pat"},  32'(pat_sel),    pat);
    check_eq({tag, "_cnt"},  32'(frame_cnt),  cnt);
    check_eq({tag, "_x"},    32'(box_x),      x);
    check_eq({tag, "_y"},    32'(box_y),      y);
    check_eq({tag, "_tick"}, 32'(frame_tick), tick);
  endtask

  int exp_pat[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int exp_cnt[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  int exp_x[9]   = '{0, 3, 6, 9, 12, 9, 6, 3, 0};
  int exp_y[9]   = '{0, 3, 4, 1, 0, 3, 4, 1, 0};

  initial begin
    rst_pix  = 1'b1;
    next_req = 1'b0;
    hold     = 1'b0;
    h        = 13'd5;
    v        = 13'd3;
    active   = 1'b1;
    mid(3);
    rst_pix = 1'b0;
    exp_out("reset", 0, 0, 0, 0, 0);
    ticks_seen = 0;

    // Free run: first update only leaves SYNC_WAIT, then box and pattern move.
    for (int i = 0; i < 9; i++) begin
      to_upd();
      if (i > 0) check_eq($sformatf("pre_upd%0d_x", i), 32'(box_x), exp_x[i-1]);
      cyc();
      exp_out($sformatf("upd%0d", i), exp_pat[i], exp_cnt[i], exp_x[i], exp_y[i], 1);
      cyc();
      check_eq($sformatf("tick_low%0d", i), 32'(frame_tick), 0);
    end
    check_eq("ticks_per_frame", ticks_seen, 9);

    // Three requests in one frame give a single advance.
    mid(30); pulse_req(); mid(10); pulse_req(); mid(10); pulse_req();
    frame();
    exp_out("multi_req", 1, 0, 3, 3, 1);

    // Manual and auto advance in the same frame count once.
    frame();
    exp_out("pre_both", 1, 1, 6, 4, 1);
    mid(20); pulse_req();
    frame();
    exp_out("both_adv", 2, 0, 9, 1, 1);

    // Hold for three frames with one request, then release.
    hold = 1'b1;
    mid(20); pulse_req();
    frame();
    exp_out("hold1", 3, 0, 9, 1, 1);
    frame();
    exp_out("hold2", 3, 0, 9, 1, 1);
    frame();
    exp_out("hold3", 3, 0, 9, 1, 1);
    hold = 1'b0;
    frame();
    exp_out("release", 3, 1, 12, 0, 1);

    // Restart and walk the box to (9,1), then reset mid-frame with a pending request.
    mid(20);
    rst_pix = 1'b1;
    cyc();
    rst_pix = 1'b0;
    exp_out("rst2", 0, 0, 0, 0, 0);
    frame(); exp_out("r2_a", 0, 0, 0, 0, 1);
    frame(); exp_out("r2_b", 0, 1, 3, 3, 1);
    frame(); exp_out("r2_c", 1, 0, 6, 4, 1);
    frame(); exp_out("r2_d", 1, 1, 9, 1, 1);
    mid(20); pulse_req(); mid(10);
    rst_pix = 1'b1;
    cyc();
    exp_out("rst_mid", 0, 0, 0, 0, 0);
    rst_pix = 1'b0;
    frame();
    exp_out("after_rst", 0, 0, 0, 0, 1);
    frame();
    exp_out("after_rst2", 0, 1, 3, 3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
